// File: rtl/quantize_stream_if.sv
// Block-level bus of the JPEG quantizer: start/config/pixels in, status and
// quantized coefficients out.
interface quantize_stream_if #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 8
);
  logic                  start;
  logic                  table_sel;
  logic                  round_en;
  logic [IN_W*64-1:0]    pixels;
  logic                  busy;
  logic                  done;
  logic [OUT_W*64-1:0]   q_result;
  logic                  sat_any;

  modport master (
    output start, table_sel, round_en, pixels,
    input  busy, done, q_result, sat_any
  );

  modport slave (
    input  start, table_sel, round_en, pixels,
    output busy, done, q_result, sat_any
  );
endinterface

// File: rtl/quantize_stream.sv
// JPEG quantizer: multiplies a latched 64-coefficient Q16.16 block by a
// reciprocal table, LANES coefficients per cycle, with saturation.
module quantize_stream #(
  parameter int IN_W       = 32,
  parameter int OUT_W      = 8,
  parameter int LANES      = 8,
  parameter int ZIGZAG_OUT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  quantize_stream_if.slave  bus
);

  localparam int N  = 64 / LANES;
  localparam int GW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = IN_W + 33;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 ||
        LANES == 16 || LANES == 32 || LANES == 64)) begin : g_bad_lanes
    $error("quantize_stream: LANES must be one of 1,2,4,8,16,32,64");
  end
  if (OUT_W < 2 || OUT_W > 16) begin : g_bad_out_w
    $error("quantize_stream: OUT_W must be within 2..16");
  end

  // Standard JPEG quantization tables, raster order, index 0 first.
  localparam logic [64*8-1:0] LUMA_Q = {
    8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
    8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
    8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
    8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
    8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
    8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
    8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
    8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99};

  localparam logic [64*8-1:0] CHROMA_Q = {
    8'd17, 8'd18, 8'd24, 8'd47, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd18, 8'd21, 8'd26, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd24, 8'd26, 8'd56, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd47, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    {32{8'd99}}};

  // Zigzag scan: slot k reads raster ZZ[k], index 0 first.
  localparam logic [64*6-1:0] ZZ = {
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63};

  // Reciprocal ROM entry i = round(65536 / Q[i]), packed with entry 0 at LSB.
  function automatic logic [64*32-1:0] build_rom(input logic [64*8-1:0] q);
    logic [64*32-1:0] r;
    r = '0;
    for (int i = 0; i < 64; i++)
      r[32*i +: 32] = (32'd65536 + 32'(q[8*(63-i) +: 8] >> 1)) / 32'(q[8*(63-i) +: 8]);
    return r;
  endfunction

  // Inverse zigzag: entry r is the output slot that raster r lands in.
  function automatic logic [64*6-1:0] build_izz(input logic [64*6-1:0] zz);
    logic [64*6-1:0] r;
    r = '0;
    for (int k = 0; k < 64; k++)
      r[6*int'(zz[6*(63-k) +: 6]) +: 6] = 6'(k);
    return r;
  endfunction

  localparam logic [64*32-1:0] LUMA_R   = build_rom(LUMA_Q);
  localparam logic [64*32-1:0] CHROMA_R = build_rom(CHROMA_Q);
  localparam logic [64*6-1:0]  IZZ      = build_izz(ZZ);

  localparam logic signed [PW-1:0] HALF = {{(PW-32){1'b0}}, 32'h8000_0000};
  localparam logic signed [PW-1:0] VMAX = PW'(2**(OUT_W-1) - 1);
  localparam logic signed [PW-1:0] VMIN = PW'(-(2**(OUT_W-1)));

  logic [1:0]               state;
  logic [GW-1:0]            grp;
  logic [IN_W*64-1:0]       pix_q;
  logic                     tbl_q;
  logic                     rnd_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     sat_q;
  logic [OUT_W*64-1:0]      res_q;
  logic                     op_valid;
  logic [GW-1:0]            op_grp;
  logic signed [IN_W-1:0]   op_pix   [LANES];
  logic [31:0]              op_recip [LANES];

  logic [OUT_W-1:0]         lane_val  [LANES];
  logic [5:0]               lane_slot [LANES];
  logic [LANES-1:0]         lane_sat;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [PW-1:0] a_ext, b_ext, prod, biased, shifted;
    logic                 sat_hi, sat_lo;
    int                   raster;

    assign a_ext   = PW'(op_pix[l]);
    assign b_ext   = PW'({1'b0, op_recip[l]});
    assign prod    = a_ext * b_ext;
    assign biased  = rnd_q ? prod + HALF : prod;
    assign shifted = biased >>> 32;
    assign sat_hi  = shifted > VMAX;
    assign sat_lo  = shifted < VMIN;

    assign lane_val[l] = sat_hi ? VMAX[OUT_W-1:0] :
                         sat_lo ? VMIN[OUT_W-1:0] : shifted[OUT_W-1:0];
    assign lane_sat[l] = sat_hi | sat_lo;

    assign raster       = int'(op_grp) * LANES + l;
    assign lane_slot[l] = (ZIGZAG_OUT != 0) ? IZZ[6*raster +: 6] : 6'(raster);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data path (latched block, operands, results) is reset along
      // with control so a reset mid-block leaves nothing stale on q_result.
      state    <= S_IDLE;
      grp      <= '0;
      pix_q    <= '0;
      tbl_q    <= 1'b0;
      rnd_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sat_q    <= 1'b0;
      res_q    <= '0;
      op_valid <= 1'b0;
      op_grp   <= '0;
      for (int l = 0; l < LANES; l++) begin
        op_pix[l]   <= '0;
        op_recip[l] <= '0;
      end
    end else begin
      done_q   <= 1'b0;
      op_valid <= 1'b0;

      // Write-back stage: results of the operands loaded on the previous edge.
      if (op_valid) begin
        for (int l = 0; l < LANES; l++)
          res_q[OUT_W*int'(lane_slot[l]) +: OUT_W] <= lane_val[l];
        sat_q <= sat_q | (|lane_sat);
      end

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            pix_q  <= bus.pixels;
            tbl_q  <= bus.table_sel;
            rnd_q  <= bus.round_en;
            busy_q <= 1'b1;
            sat_q  <= 1'b0;
            grp    <= '0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          for (int l = 0; l < LANES; l++) begin
            op_pix[l]   <= pix_q[IN_W*(int'(grp)*LANES + l) +: IN_W];
            op_recip[l] <= tbl_q ? CHROMA_R[32*(int'(grp)*LANES + l) +: 32]
                                 : LUMA_R[32*(int'(grp)*LANES + l) +: 32];
          end
          op_valid <= 1'b1;
          op_grp   <= grp;
          if (grp == GW'(N-1)) state <= S_DONE;
          else                 grp   <= grp + GW'(1);
        end
        S_DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.q_result = res_q;
  assign bus.sat_any  = sat_q;

endmodule

// File: tb/tb_quantize_stream.sv
// Scoreboard bench: four quantizer configurations share pixels/config, each
// with its own start line; a monitor compares every done against a real-number model.
module tb_quantize_stream;

  typedef struct {
    logic [511:0] q;
    logic         sat;
    int           due;
  } exp_t;

  localparam int LN  [4] = '{8, 8, 1, 64};
  localparam bit ZZF [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  int q_luma [64] = '{
    16, 11, 10, 16, 24, 40, 51, 61,
    12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,
    14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68, 109, 103, 77,
    24, 35, 55, 64, 81, 104, 113, 92,
    49, 64, 78, 87, 103, 121, 120, 101,
    72, 92, 95, 98, 112, 100, 103, 99};
  int q_chroma [64] = '{
    17, 18, 24, 47, 99, 99, 99, 99,
    18, 21, 26, 66, 99, 99, 99, 99,
    24, 26, 56, 99, 99, 99, 99, 99,
    47, 66, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99};
  int zz [64];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] start_m;
  logic tsel, rnd;
  logic signed [31:0] px [64];
  logic [2047:0] pix_bus;

  logic [3:0]   done_v, busy_v, sat_v;
  logic [511:0] qres_v [4];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  exp_t exp_q [4][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    pix_bus = '0;
    for (int i = 0; i < 64; i++) pix_bus[32*i +: 32] = px[i];
  end

  quantize_stream_if #(.IN_W(32), .OUT_W(8)) b0 ();
  quantize_stream_if #(.IN_W(32), .OUT_W(8)) b1 ();
  quantize_stream_if #(.IN_W(32), .OUT_W(8)) b2 ();
  quantize_stream_if #(.IN_W(32), .OUT_W(8)) b3 ();

  assign b0.start = start_m[0]; assign b0.table_sel = tsel; assign b0.round_en = rnd; assign b0.pixels = pix_bus;
  assign b1.start = start_m[1]; assign b1.table_sel = tsel; assign b1.round_en = rnd; assign b1.pixels = pix_bus;
  assign b2.start = start_m[2]; assign b2.table_sel = tsel; assign b2.round_en = rnd; assign b2.pixels = pix_bus;
  assign b3.start = start_m[3]; assign b3.table_sel = tsel; assign b3.round_en = rnd; assign b3.pixels = pix_bus;

  assign done_v = {b3.done, b2.done, b1.done, b0.done};
  assign busy_v = {b3.busy, b2.busy, b1.busy, b0.busy};
  assign sat_v  = {b3.sat_any, b2.sat_any, b1.sat_any, b0.sat_any};
  assign qres_v[0] = b0.q_result;
  assign qres_v[1] = b1.q_result;
  assign qres_v[2] = b2.q_result;
  assign qres_v[3] = b3.q_result;

  quantize_stream #(.IN_W(32), .OUT_W(8), .LANES(8),  .ZIGZAG_OUT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  quantize_stream #(.IN_W(32), .OUT_W(8), .LANES(8),  .ZIGZAG_OUT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  quantize_stream #(.IN_W(32), .OUT_W(8), .LANES(1),  .ZIGZAG_OUT(0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  quantize_stream #(.IN_W(32), .OUT_W(8), .LANES(64), .ZIGZAG_OUT(1)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Quantized value of one coefficient from the real-valued definition.
  function automatic int ref_coef(input longint pix, input int q, input bit r, output bit sat);
    int  recip;
    real x, v;
    recip = $rtoi(65536.0 / q + 0.5);
    x = real'(pix) * real'(recip) / 4294967296.0;
    v = r ? $floor(x + 0.5) : $floor(x);
    sat = 1'b0;
    if (v > 127.0)  begin sat = 1'b1; return 127;  end
    if (v < -128.0) begin sat = 1'b1; return -128; end
    return $rtoi(v);
  endfunction

  function automatic exp_t make_exp(input int d);
    exp_t e;
    int   val [64];
    bit   s, any;
    any = 1'b0;
    for (int r = 0; r < 64; r++) begin
      val[r] = ref_coef(longint'(px[r]), tsel ? q_chroma[r] : q_luma[r], rnd, s);
      any |= s;
    end
    e.q = '0;
    for (int k = 0; k < 64; k++)
      e.q[8*k +: 8] = 8'(ZZF[d] ? val[zz[k]] : val[k]);
    e.sat = any;
    e.due = cyc + 64 / LN[d] + 2;
    return e;
  endfunction

  // Called just after a negedge: raises start on the selected DUTs for one cycle.
  task automatic issue(input logic [3:0] mask);
    for (int d = 0; d < 4; d++)
      if (mask[d]) exp_q[d].push_back(make_exp(d));
    start_m = mask;
    @(negedge clk);
    start_m = '0;
    for (int d = 0; d < 4; d++)
      if (mask[d]) check($sformatf("busy_after_start dut%0d", d), 512'(busy_v[d]), 512'(1));
  endtask

  task automatic wait_all();
    int t;
    t = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("wait_all_timeout", 512'(t), 512'(0));
  endtask

  task automatic rand_pixels();
    for (int i = 0; i < 64; i++)
      if ($urandom_range(0, 3) == 0) px[i] = $urandom;
      else px[i] = $signed($urandom_range(0, 400 << 16)) - (200 << 16);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 4; d++) begin
        if (done_v[d]) begin
          if (exp_q[d].size() == 0) begin
            check($sformatf("spurious_done dut%0d", d), 512'(1), 512'(0));
          end else begin
            exp_t e;
            e = exp_q[d].pop_front();
            check($sformatf("q_result dut%0d", d), qres_v[d], e.q);
            check($sformatf("sat_any dut%0d", d), 512'(sat_v[d]), 512'(e.sat));
            check($sformatf("done_cycle dut%0d", d), 512'(cyc), 512'(e.due));
            check($sformatf("busy_at_done dut%0d", d), 512'(busy_v[d]), 512'(0));
          end
        end else if (exp_q[d].size() > 0 && cyc > exp_q[d][0].due) begin
          check($sformatf("done_missing dut%0d", d), 512'(cyc), 512'(exp_q[d][0].due));
          void'(exp_q[d].pop_front());
        end
      end
    end
  end

  initial begin
    int n, due0;
    n = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0)
        for (int r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin zz[n] = r*8 + (s-r); n++; end
      else
        for (int r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) begin zz[n] = r*8 + (s-r); n++; end
    end

    start_m = '0; tsel = 1'b0; rnd = 1'b0;
    for (int i = 0; i < 64; i++) px[i] = 32'h0010_0000;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("reset_q dut%0d", d), qres_v[d], '0);
      check($sformatf("reset_ctl dut%0d", d), 512'({busy_v[d], done_v[d], sat_v[d]}), 512'(0));
    end
    rst_n = 1'b1;
    @(negedge clk);

    // All 16.0, luma, floor.
    issue(4'hF);
    wait_all();
    check("flat16 slot0", 512'(qres_v[0][7:0]), 512'(8'd1));
    check("flat16 slot1", 512'(qres_v[0][15:8]), 512'(8'd1));
    check("flat16 sat", 512'(sat_v[0]), 512'(0));

    // Rounding on +/-24.0.
    for (int i = 0; i < 64; i++) px[i] = 0;
    for (int k = 0; k < 4; k++) begin
      px[0] = (k < 2) ? 32'h0018_0000 : 32'hFFE8_0000;
      rnd = k[0];
      issue(4'hF);
      wait_all();
      case (k)
        0: check("round +24 floor", 512'(qres_v[0][7:0]), 512'(8'd1));
        1: check("round +24 half", 512'(qres_v[0][7:0]), 512'(8'd2));
        2: check("round -24 floor", 512'(qres_v[0][7:0]), 512'(8'hFE));
        default: check("round -24 half", 512'(qres_v[0][7:0]), 512'(8'hFF));
      endcase
    end

    // Saturation both ways, then a clean block clears sat_any.
    rnd = 1'b0;
    px[0] = 32'h7FFF_0000;
    issue(4'hF); wait_all();
    check("sat_pos value", 512'(qres_v[0][7:0]), 512'(8'd127));
    check("sat_pos flag", 512'(sat_v[0]), 512'(1));
    px[0] = 32'h8000_0000;
    issue(4'hF); wait_all();
    check("sat_neg value", 512'(qres_v[0][7:0]), 512'(8'h80));
    check("sat_neg flag", 512'(sat_v[0]), 512'(1));
    px[0] = 0;
    issue(4'hF); wait_all();
    check("sat_cleared", 512'(sat_v[0]), 512'(0));

    // Chroma, inputs disturbed right after start.
    tsel = 1'b1;
    px[4] = 32'h0063_0000;
    issue(4'hF);
    rand_pixels();
    tsel = 1'b0;
    wait_all();
    check("chroma slot4", 512'(qres_v[0][39:32]), 512'(8'd1));

    // Zigzag ramp.
    for (int i = 0; i < 64; i++) px[i] = (i % 16) << 20;
    issue(4'hF); wait_all();
    check("zigzag slot2 dut1", 512'(qres_v[1][23:16]), 512'(8'd10));
    check("zigzag slot3 dut1", 512'(qres_v[1][31:24]), 512'(8'd0));
    check("zigzag slot2 dut3", 512'(qres_v[3][23:16]), 512'(8'd10));

    // Start pulsed while busy must be dropped.
    rand_pixels();
    issue(4'hF);
    @(negedge clk);
    start_m = 4'hF;
    @(negedge clk);
    start_m = '0;
    wait_all();
    repeat (80) @(negedge clk);

    // Back-to-back blocks on dut0.
    rand_pixels();
    due0 = cyc + 10;
    issue(4'b0001);
    while (cyc < due0) @(negedge clk);
    rand_pixels();
    tsel = 1'b1;
    issue(4'b0001);
    wait_all();

    // Reset in the middle of a block.
    tsel = 1'b0;
    rand_pixels();
    issue(4'hF);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) begin
      check($sformatf("midreset_q dut%0d", d), qres_v[d], '0);
      check($sformatf("midreset_ctl dut%0d", d), 512'({busy_v[d], done_v[d], sat_v[d]}), 512'(0));
      exp_q[d].delete();
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rand_pixels();
    issue(4'hF);
    wait_all();

    // Random blocks.
    for (int t = 0; t < 12; t++) begin
      rand_pixels();
      tsel = 1'($urandom_range(0, 1));
      rnd  = 1'($urandom_range(0, 1));
      issue(4'hF);
      wait_all();
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/quantize_stream.md
Name: quantize_stream

Overview:
- Parametrised JPEG quantizer that multiplies a 64-coefficient DCT block (Q16.16) by a reciprocal quantization table and produces saturated signed integer coefficients.
- Luma/chroma table is chosen at run time per block. Lane count, output width, rounding and output ordering (raster or zigzag) are configurable.
- Sits between the DCT stage and the entropy coder.
- Latches its input block at start, so the upstream stage may change pixels immediately afterwards.

Parameters:
- IN_W, 32: coefficient width, signed Q16.16.
- OUT_W, 8: output width, signed two's complement; 2..16.
- LANES, 8: multipliers working in parallel; one of 1,2,4,8,16,32,64. Any other value is an elaboration error.
- ZIGZAG_OUT, 0: 0 = q_result in raster order; 1 = q_result in JPEG zigzag order.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request to process a block; sampled only in IDLE
- table_sel  in  1  0 = luma table, 1 = chroma table; latched with start
- round_en  in  1  0 = floor, 1 = round half up; latched with start
- pixels  in  IN_W*64  coefficient i (raster order) at [IN_W*i +: IN_W]
- busy  out  1  high while a block is in flight
- done  out  1  one-cycle pulse; q_result and sat_any are valid from this cycle onward
- q_result  out  OUT_W*64  slot k at [OUT_W*k +: OUT_W]
- sat_any  out  1  at least one coefficient of the last block saturated

Behaviour:
- Clocking and reset: one clock domain, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: state IDLE, busy 0, done 0, q_result all 0, sat_any 0, group counter 0, all pipeline registers 0.
- Tables: the team-standard JPEG reciprocal ROMs, 64 x 32-bit, each entry = 1/Q in Q16.16.
  - luma[0] = 0x00001000 (1/16); luma[1] = 0x00001746.
  - chroma[0] = 0x00000F0F; chroma[4] = 0x00000296.
- Number of groups N = 64/LANES. Group g covers raster indices g*LANES .. g*LANES+LANES-1.
- States:
  - IDLE -> RUN when start=1. At that edge E0: capture pixels, table_sel and round_en; set busy=1; clear sat_any.
  - RUN: at edge E0+1+g (g = 0..N-1), load group g pixels and table entries into the operand registers. Each lane's result is written into q_result one edge after its operands are loaded.
  - RUN -> DONE after the edge that loads group N-1.
  - DONE: at edge E0+N+1, write group N-1, pulse done=1 for one cycle, set busy=0, return to IDLE.
- Latency: done is high in the cycle after edge E0+N+1. With LANES=8 that is edge E0+9; with LANES=64, edge E0+2.
- start while busy=1 is ignored, not queued. start in the same cycle as done's IDLE return is accepted; back-to-back blocks run with no gap cycle.
- Arithmetic, per lane:
  - p = signed(pixel) * unsigned(recip), 64-bit signed, Q32.32.
  - If round_en=1, add 2^31.
  - v = p >>> 32 (arithmetic shift, i.e. floor).
  - Saturate v to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Any clipping in the block ORs into sat_any.
- Output ordering:
  - ZIGZAG_OUT=0: slot k = raster k.
  - ZIGZAG_OUT=1: slot k = raster ZZ[k], with ZZ = 0,1,8,16,9,2,3,10,17,24,... (standard JPEG zigzag).
- q_result slots already written keep their value until overwritten by the next block. Only read q_result when done is high or afterwards.
- Reset mid-block: all outputs return to reset values immediately; the block in flight is discarded. The first start after reset must behave normally.
- No combinational path from any input to any output.

Test Plan:
- Luma, LANES=8, round_en=0, all pixels 0x00100000 (16.0):
  - slot 0 = 1, slot 1 = 1 (16 x 0x1746 / 2^16 = 1.45);
  - done edge E0+9; busy high E0..E0+9; sat_any = 0.
- Rounding, luma, raster 0 = 0x00180000 (24.0):
  - round_en=0 gives 1; round_en=1 gives 2.
  - For -24.0 (0xFFE80000): round_en=0 gives -2; round_en=1 gives -1.
- Saturation, OUT_W=8, luma:
  - raster 0 = 0x7FFF0000 -> 127; raster 0 = 0x80000000 -> -128; sat_any=1 in both cases.
  - Next block with all zeros -> sat_any=0.
- Chroma, table_sel=1, raster 4 = 0x00630000 (99.0) -> 1.
  - Change pixels and table_sel one cycle after start -> results unchanged (input latched).
- ZIGZAG_OUT=1, pixel i = (i mod 16) x 16.0, luma, round_en=0:
  - slot 2 holds raster 8's result; slot 3 holds raster 16's.
  - Check against a golden model for all 64 slots.
- Control and sweep:
  - start pulsed during busy -> ignored (one done pulse only).
  - rst_n low at edge E0+4 -> q_result=0, done=0, busy=0 asynchronously; the following start completes correctly.
  - Repeat for LANES=1 (done at E0+65) and LANES=64 (done at E0+2).
